// File: rtl/serialdp_serial_tx.sv
// serialdp_serial_tx
// Byte-to-serial frame transmitter for the serial datapath.
// Each byte accepted over a valid/ready handshake is sent as one frame:
//   start (0), d0..d7 LSB first, stop (1).
// Every frame bit is held on the line for CLKS_PER_BIT cycles.
// An optional IDLE_GAP of high cycles follows the stop bit.
// All outputs are flops, so there is no combinational path from tx_valid.
module serialdp_serial_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int IDLE_GAP     = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frames_sent
);

    // Bit-time counter spans 0..CLKS_PER_BIT-1.
    // The gap counter keeps at least one bit so the design still elaborates when IDLE_GAP is 0.
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
    // Cycle before the last stop-bit cycle.
    // It is only used when CLKS_PER_BIT >= 2.
    localparam logic [BW-1:0] BIT_PRE  = BW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t          state;
    logic [7:0]      shreg;
    logic [BW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [GW-1:0]   gap_cnt;

    // Frame sequencer.
    // Next-cycle values of serial_out, tx_ready, busy and frame_done are registered
    // together with the state, so they all change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            serial_out  <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            gap_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    serial_out <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shreg      <= tx_data;
                        state      <= S_START;
                        serial_out <= 1'b0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        bit_cnt    <= '0;
                    end
                end

                S_START: begin
                    if (bit_cnt == BIT_LAST) begin
                        // Present d0 and pre-shift, so shreg[0] always holds the next bit to send.
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        serial_out <= shreg[0];
                        shreg      <= {1'b0, shreg[7:1]};
                        state      <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state      <= S_STOP;
                            serial_out <= 1'b1;
                            // A one-cycle stop bit is also its own final cycle.
                            frame_done <= (CLKS_PER_BIT == 1);
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            serial_out <= shreg[0];
                            shreg      <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    serial_out <= 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt     <= '0;
                        frames_sent <= frames_sent + 1'b1;
                        if (IDLE_GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end else begin
                            state    <= S_IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        bit_cnt    <= bit_cnt + 1'b1;
                        frame_done <= (bit_cnt == BIT_PRE);
                    end
                end

                S_GAP: begin
                    serial_out <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= '0;
                        state    <= S_IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    serial_out <= 1'b1;
                    tx_ready   <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serialdp_serial_tx.sv
// Directed bench for serialdp_serial_tx.
// It uses three instances:
//   a: CPB=1, no gap
//   b: CPB=4, gap of 3, 4-bit counter
//   c: CPB=2, gap of 1, 4-bit counter; a bench-side receiver checks it in loopback.
module tb_serialdp_serial_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready, a_serial, a_busy, a_done;
    logic [15:0] a_fs;

    logic [7:0]  b_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_serial, b_busy, b_done;
    logic [3:0]  b_fs;

    logic [7:0]  c_data = '0;
    logic        c_valid = 1'b0;
    logic        c_ready, c_serial, c_busy, c_done;
    logic [3:0]  c_fs;

    serialdp_serial_tx #(.CLKS_PER_BIT(1), .IDLE_GAP(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
        .serial_out(a_serial), .busy(a_busy), .frame_done(a_done), .frames_sent(a_fs)
    );

    serialdp_serial_tx #(.CLKS_PER_BIT(4), .IDLE_GAP(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
        .serial_out(b_serial), .busy(b_busy), .frame_done(b_done), .frames_sent(b_fs)
    );

    serialdp_serial_tx #(.CLKS_PER_BIT(2), .IDLE_GAP(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .tx_data(c_data), .tx_valid(c_valid), .tx_ready(c_ready),
        .serial_out(c_serial), .busy(c_busy), .frame_done(c_done), .frames_sent(c_fs)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a byte to instance a for one cycle. Instance a must be idle.
    task automatic a_send(input logic [7:0] b);
        @(posedge clk); #1;
        a_data  = b;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    // Check the 10 frame cycles that follow an accept on instance a.
    task automatic a_frame_expect(input logic [7:0] b, input string tag);
        logic exp_bit;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0)      exp_bit = 1'b0;
            else if (i == 9) exp_bit = 1'b1;
            else             exp_bit = b[i-1];
            check({tag, "_line"}, 32'(a_serial), 32'(exp_bit));
            check({tag, "_done"}, 32'(a_done), 32'(i == 9));
            check({tag, "_ready"}, 32'(a_ready), 0);
        end
    endtask

    // Hard stop in case a wait is ever left unbounded.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a5_bits [10];
        logic       exp_bit;
        logic [7:0] b, rx;
        logic [7:0] b3c;
        int         t, done_cnt;
        logic       stop_ok;

        a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // ---- Test 1: async reset takes effect before any clock edge ----
        #2 rst = 1'b1;
        #1;
        check("rst_line", 32'(a_serial), 1);
        check("rst_ready", 32'(a_ready), 1);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_done", 32'(a_done), 0);
        check("rst_fs", 32'(a_fs), 0);
        check("rst_fs_b", 32'(b_fs), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- Test 2: 0xA5 at CPB=1 ----
        a_send(8'hA5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a5_line", 32'(a_serial), 32'(a5_bits[i]));
            check("a5_done", 32'(a_done), 32'(i == 9));
            check("a5_busy", 32'(a_busy), 1);
        end
        @(negedge clk);
        check("a5_fs", 32'(a_fs), 1);
        check("a5_ready_after", 32'(a_ready), 1);
        check("a5_busy_after", 32'(a_busy), 0);

        // ---- Test 3: back-to-back 0x00 then 0xFF with tx_valid held ----
        // The bench is mid idle cycle c0, so the byte is accepted at the end of c0.
        a_data  = 8'h00;
        a_valid = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (i == 1)  a_data = 8'hFF;
            if (i == 12) a_valid = 1'b0;
            if (i >= 1 && i <= 9)        exp_bit = 1'b0;
            else if (i == 10 || i == 11) exp_bit = 1'b1;
            else if (i == 12)            exp_bit = 1'b0;
            else                         exp_bit = 1'b1;
            check("b2b_line", 32'(a_serial), 32'(exp_bit));
            check("b2b_ready", 32'(a_ready), 32'(i == 11));
        end
        @(negedge clk);
        check("b2b_fs", 32'(a_fs), 3);

        // ---- Test 5: reset during data bit 4 aborts the frame ----
        a_data  = 8'h00;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        for (int i = 1; i <= 6; i++) @(negedge clk);
        check("abort_line_before", 32'(a_serial), 0);
        check("abort_busy_before", 32'(a_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_line", 32'(a_serial), 1);
        check("abort_ready", 32'(a_ready), 1);
        check("abort_busy", 32'(a_busy), 0);
        check("abort_fs", 32'(a_fs), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        a_send(8'h81);
        a_frame_expect(8'h81, "x81");
        @(negedge clk);
        check("x81_fs", 32'(a_fs), 1);

        // ---- Test 4: CPB=4, IDLE_GAP=3, 0x3C ----
        b3c = 8'h3C;
        @(negedge clk);
        check("b_idle_ready", 32'(b_ready), 1);
        b_data  = b3c;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        b_data  = 8'hFF;
        for (int i = 1; i <= 44; i++) begin
            @(negedge clk);
            if (i <= 4)       exp_bit = 1'b0;
            else if (i <= 36) exp_bit = b3c[(i - 5) / 4];
            else              exp_bit = 1'b1;
            check("cpb4_line", 32'(b_serial), 32'(exp_bit));
            check("cpb4_ready", 32'(b_ready), 32'(i == 44));
            check("cpb4_done", 32'(b_done), 32'(i == 40));
        end
        check("cpb4_fs", 32'(b_fs), 1);

        // ---- Test 6: loopback of 256 random bytes on instance c; frames_sent wraps at 16 ----
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom_range(0, 255));
            t = 0;
            @(negedge clk);
            while (!c_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("lb_ready_wait", 32'(c_ready), 1);
            c_data  = b;
            c_valid = 1'b1;
            @(posedge clk); #1;
            c_valid = 1'b0;
            c_data  = 8'($urandom_range(0, 255));
            // Hunt for the start bit, up to 10 cycles.
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (c_serial !== 1'b0 && t < 10);
            check("lb_start", 32'(c_serial), 0);
            done_cnt = c_done ? 1 : 0;
            rx       = '0;
            stop_ok  = 1'b1;
            for (int j = 1; j < 20; j++) begin
                @(negedge clk);
                if (c_done) done_cnt++;
                if (j >= 3 && j <= 17 && (j % 2) == 1) rx[(j - 3) / 2] = c_serial;
                if (j >= 18) stop_ok = stop_ok & c_serial;
            end
            check("lb_byte", 32'(rx), 32'(b));
            check("lb_done_count", done_cnt, 1);
            check("lb_stop", 32'(stop_ok), 1);
            @(negedge clk);
            check("lb_fs_wrap", 32'(c_fs), (n + 1) % 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
